video_mode_detect: RTL and testbench

- Measures incoming raw video timing (hsync/vsync/de) and reports line/frame geometry once it is stable across several frames.
- Inverse direction of the mode-configuration path: that path turns a mode index into timing; this block turns observed timing into geometry.
- Downstream logic matches the geometry against the mode table to produce the `MODE_SIZE index.
- Sits on the video input side, in the pixel clock domain.

---
 rtl/video_mode_detect.sv | 248 ++++++++++++++++++++++++
 tb/tb_video_mode_detect.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/video_mode_detect.sv
// Measures raw hsync/vsync/de timing and reports line/frame geometry once it has been stable for several frames.
// Optional macro VIDEO_DETECT_POLARITY_EN adds sync polarity detection and the hsync_pol/vsync_pol outputs.
module video_mode_detect #(
    parameter int CNT_W         = 12,
    parameter int STABLE_FRAMES = 3,
    parameter int TIMEOUT       = 4194304
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             hsync,
    input  logic             vsync,
    input  logic             de,
    output logic [CNT_W-1:0] h_total,
    output logic [CNT_W-1:0] h_active,
    output logic [CNT_W-1:0] v_total,
    output logic [CNT_W-1:0] v_active,
    output logic             locked,
    output logic             mode_changed,
    output logic             signal_lost
`ifdef VIDEO_DETECT_POLARITY_EN
    ,
    output logic             hsync_pol,
    output logic             vsync_pol
`endif
);

    localparam logic [CNT_W-1:0] CMAX     = '1;
    localparam int               TO_W     = $clog2(TIMEOUT + 1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);
    localparam logic [TO_W-1:0]  TO_FULL  = TO_W'(TIMEOUT);
    localparam logic [3:0]       STABLE_N = 4'(STABLE_FRAMES);

    typedef enum logic {UNLOCKED = 1'b0, LOCKED = 1'b1} lock_state_t;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CMAX) ? v : v + 1'b1;
    endfunction

    logic             hs_n, vs_n, hs_r, vs_r, hs_edge, vs_edge, line_de;
    logic [CNT_W-1:0] h_cnt, de_cnt, h_meas, ha_meas, v_cnt, va_cnt, h_inc;
    logic             frame_sat, sat_now;
    logic [CNT_W-1:0] cand_h, cand_ha, cand_v, cand_va;
    logic [CNT_W-1:0] prev_h, prev_ha, prev_v, prev_va;
    logic [1:0]       cand_pol, prev_pol;
    logic             cand_ok, cand_eq, have_prev, first_edge_seen, frame_close;
    logic [3:0]       stable_cnt;
    logic [TO_W-1:0]  to_cnt;
    logic             timeout_fire, bad_evt, load_geom, geom_diff, ever_locked;
    lock_state_t      state, state_next;

`ifdef VIDEO_DETECT_POLARITY_EN
    // The level held for most of a period is the inactive one; syncs are normalized to active-high.
    logic [CNT_W-1:0] hs_hi, hs_lo, vs_hi, vs_lo;
    logic             hs_raw_r, vs_raw_r, hs_pol_det, vs_pol_det;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hs_raw_r   <= 1'b0;
            vs_raw_r   <= 1'b0;
            hs_pol_det <= 1'b0;
            vs_pol_det <= 1'b0;
            hs_hi      <= '0;
            hs_lo      <= '0;
            vs_hi      <= '0;
            vs_lo      <= '0;
        end else begin
            hs_raw_r <= hsync;
            vs_raw_r <= vsync;
            if (hsync && !hs_raw_r) begin
                hs_pol_det <= (hs_hi > hs_lo);
                hs_hi      <= '0;
                hs_lo      <= '0;
            end else if (hsync) hs_hi <= sat_inc(hs_hi);
            else                hs_lo <= sat_inc(hs_lo);
            if (vsync && !vs_raw_r) begin
                vs_pol_det <= (vs_hi > vs_lo);
                vs_hi      <= '0;
                vs_lo      <= '0;
            end else if (vsync) vs_hi <= sat_inc(vs_hi);
            else                vs_lo <= sat_inc(vs_lo);
        end
    end

    assign hs_n      = hsync ^ hs_pol_det;
    assign vs_n      = vsync ^ vs_pol_det;
    assign cand_pol  = {hs_pol_det, vs_pol_det};
    assign geom_diff = {prev_h, prev_ha, prev_v, prev_va, prev_pol} !=
                       {h_total, h_active, v_total, v_active, hsync_pol, vsync_pol};
`else
    assign hs_n      = hsync;
    assign vs_n      = vsync;
    assign cand_pol  = 2'b00;
    assign geom_diff = {prev_h, prev_ha, prev_v, prev_va} != {h_total, h_active, v_total, v_active};
`endif

    assign hs_edge = hs_n & ~hs_r;
    assign vs_edge = vs_n & ~vs_r;
    assign line_de = hs_edge && (de_cnt != '0);
    assign h_inc   = sat_inc(h_cnt);
    assign sat_now = (h_cnt == CMAX) || (de_cnt == CMAX) || (v_cnt == CMAX) || (va_cnt == CMAX);

    // A line closing on the same cycle as the frame belongs to the closing frame.
    assign cand_h  = hs_edge ? h_inc : h_meas;
    assign cand_ha = line_de ? de_cnt : ha_meas;
    assign cand_v  = hs_edge ? sat_inc(v_cnt) : v_cnt;
    assign cand_va = line_de ? sat_inc(va_cnt) : va_cnt;
    assign cand_ok = (cand_h != '0) && (cand_ha != '0) && (cand_v != '0) && (cand_va != '0) &&
                     (cand_h != CMAX) && (cand_ha != CMAX) && (cand_v != CMAX) && (cand_va != CMAX) &&
                     !frame_sat && !sat_now;
    assign cand_eq = have_prev &&
                     ({cand_h, cand_ha, cand_v, cand_va, cand_pol} == {prev_h, prev_ha, prev_v, prev_va, prev_pol});

    assign frame_close  = vs_edge && first_edge_seen;
    assign timeout_fire = (to_cnt == TO_LAST) && !vs_edge;
    assign bad_evt      = timeout_fire || (frame_close && !(cand_ok && cand_eq));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hs_r      <= 1'b0;
            vs_r      <= 1'b0;
            h_cnt     <= '0;
            de_cnt    <= '0;
            h_meas    <= '0;
            ha_meas   <= '0;
            v_cnt     <= '0;
            va_cnt    <= '0;
            frame_sat <= 1'b0;
        end else begin
            hs_r <= hs_n;
            vs_r <= vs_n;
            if (sat_now) frame_sat <= 1'b1;
            if (hs_edge) begin
                h_meas <= h_inc;
                h_cnt  <= '0;
                de_cnt <= '0;
                if (line_de) ha_meas <= de_cnt;
            end else begin
                h_cnt <= h_inc;
                if (de) de_cnt <= sat_inc(de_cnt);
            end
            if (vs_edge) begin
                v_cnt     <= '0;
                va_cnt    <= '0;
                frame_sat <= 1'b0;
            end else if (hs_edge) begin
                v_cnt <= sat_inc(v_cnt);
                if (line_de) va_cnt <= sat_inc(va_cnt);
            end
        end
    end

    // Frame qualification, stability count and vsync timeout.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            prev_h          <= '0;
            prev_ha         <= '0;
            prev_v          <= '0;
            prev_va         <= '0;
            prev_pol        <= 2'b00;
            have_prev       <= 1'b0;
            stable_cnt      <= '0;
            first_edge_seen <= 1'b0;
            signal_lost     <= 1'b0;
            to_cnt          <= '0;
        end else begin
            if (vs_edge)              to_cnt <= '0;
            else if (to_cnt != TO_FULL) to_cnt <= to_cnt + 1'b1;
            if (timeout_fire) begin
                signal_lost     <= 1'b1;
                stable_cnt      <= '0;
                have_prev       <= 1'b0;
                first_edge_seen <= 1'b0;
            end else if (vs_edge) begin
                signal_lost <= 1'b0;
                if (!first_edge_seen) begin
                    first_edge_seen <= 1'b1;
                end else if (!cand_ok) begin
                    stable_cnt <= '0;
                    have_prev  <= 1'b0;
                end else if (cand_eq) begin
                    if (stable_cnt != STABLE_N) stable_cnt <= stable_cnt + 1'b1;
                end else begin
                    stable_cnt <= 4'd1;
                    have_prev  <= 1'b1;
                    prev_h     <= cand_h;
                    prev_ha    <= cand_ha;
                    prev_v     <= cand_v;
                    prev_va    <= cand_va;
                    prev_pol   <= cand_pol;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= UNLOCKED;
        else          state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            UNLOCKED: if ((stable_cnt == STABLE_N) && !bad_evt) state_next = LOCKED;
            LOCKED:   if (bad_evt) state_next = UNLOCKED;
            default:  state_next = UNLOCKED;
        endcase
    end

    always_comb begin
        locked    = (state == LOCKED);
        load_geom = (state == UNLOCKED) && (state_next == LOCKED);
    end

    // Geometry outputs hold through loss of lock and only reload on the next lock.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_total      <= '0;
            h_active     <= '0;
            v_total      <= '0;
            v_active     <= '0;
            mode_changed <= 1'b0;
            ever_locked  <= 1'b0;
        end else begin
            mode_changed <= 1'b0;
            if (load_geom) begin
                h_total      <= prev_h;
                h_active     <= prev_ha;
                v_total      <= prev_v;
                v_active     <= prev_va;
                mode_changed <= geom_diff || !ever_locked;
                ever_locked  <= 1'b1;
            end
        end
    end

`ifdef VIDEO_DETECT_POLARITY_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            hsync_pol <= 1'b0;
            vsync_pol <= 1'b0;
        end else if (load_geom) begin
            hsync_pol <= prev_pol[1];
            vsync_pol <= prev_pol[0];
        end
    end
`endif

endmodule

// File: tb/tb_video_mode_detect.sv
// Directed bench for video_mode_detect: scaled-down video frames exercising lock, mode change, timeout,
// reset and counter saturation, with hand-computed geometry.
module tb_video_mode_detect;

  localparam int CNT_W  = 12;
  localparam int STABLE = 3;
  localparam int TO     = 8000;

  logic clock, reset_n, hsync, vsync, de;
  logic [CNT_W-1:0] h_total, h_active, v_total, v_active;
  logic locked, mode_changed, signal_lost;
`ifdef VIDEO_DETECT_POLARITY_EN
  logic hsync_pol, vsync_pol;
`endif

  int n_cmp = 0;
  int n_fail = 0;
  int steps = 0;
  int last_edge_step = 0;
  int g_ht, g_ha, g_vt, g_va, pos_l, pos_c;
  logic hs_en, vs_en;

  video_mode_detect #(.CNT_W(CNT_W), .STABLE_FRAMES(STABLE), .TIMEOUT(TO)) dut (
    .clock(clock),
    .reset_n(reset_n),
    .hsync(hsync),
    .vsync(vsync),
    .de(de),
    .h_total(h_total),
    .h_active(h_active),
    .v_total(v_total),
    .v_active(v_active),
    .locked(locked),
    .mode_changed(mode_changed),
    .signal_lost(signal_lost)
`ifdef VIDEO_DETECT_POLARITY_EN
    ,
    .hsync_pol(hsync_pol),
    .vsync_pol(vsync_pol)
`endif
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // driver: one pixel clock; hsync 2 clocks at line start, vsync 4 clocks at frame start,
  // de on columns 2..2+ha-1 of lines 0..va-1
  task automatic step();
    @(negedge clock);
    hsync = hs_en && (pos_c < 2);
    vsync = vs_en && (pos_l == 0) && (pos_c < 4);
    de    = (pos_l < g_va) && (pos_c >= 2) && (pos_c < 2 + g_ha);
    steps++;
    pos_c++;
    if (pos_c == g_ht) begin
      pos_c = 0;
      pos_l++;
      if (pos_l == g_vt) pos_l = 0;
    end
  endtask

  task automatic set_geom(input int ht, input int ha, input int vt, input int va);
    g_ht = ht; g_ha = ha; g_vt = vt; g_va = va;
    pos_l = 0; pos_c = 0;
  endtask

  task automatic run_frames(input int n);
    repeat (n * g_ht * g_vt) step();
  endtask

  task automatic run_to_frame_start();
    for (int k = 0; k < 20000 && !(pos_l == 0 && pos_c == 0); k++) step();
  endtask

  // Drives the frame edge that completes the stable run and checks the 2-clock lock latency.
  task automatic check_lock(input string tag, input int ht, input int ha, input int vt, input int va,
                            input logic exp_mc);
    step();
    last_edge_step = steps;
    step();
    chk({tag, "_not_yet"}, locked, 1'b0);
    step();
    chk({tag, "_locked"}, locked, 1'b1);
    chk({tag, "_mode_changed"}, mode_changed, exp_mc);
    chk({tag, "_h_total"}, h_total, ht);
    chk({tag, "_h_active"}, h_active, ha);
    chk({tag, "_v_total"}, v_total, vt);
    chk({tag, "_v_active"}, v_active, va);
    step();
    chk({tag, "_pulse_end"}, mode_changed, 1'b0);
  endtask

  initial begin
    reset_n = 1'b0;
    hsync = 1'b0; vsync = 1'b0; de = 1'b0;
    hs_en = 1'b1; vs_en = 1'b1;
    set_geom(20, 12, 12, 8);
    repeat (3) @(negedge clock);
    chk("rst_h_total", h_total, 0);
    chk("rst_h_active", h_active, 0);
    chk("rst_v_total", v_total, 0);
    chk("rst_v_active", v_active, 0);
    chk("rst_locked", locked, 1'b0);
    chk("rst_mode_changed", mode_changed, 1'b0);
    chk("rst_signal_lost", signal_lost, 1'b0);
    reset_n = 1'b1;

    // first lock: edge 1 discarded, edges 2..4 build the stable run
    run_frames(3);
    chk("prelock_locked", locked, 1'b0);
    check_lock("lock_a", 20, 12, 12, 8, 1'b1);
    run_to_frame_start();

    // mode change: the first B frame closes at the second B edge
    set_geom(30, 20, 15, 10);
    run_frames(1);
    chk("b1_still_locked", locked, 1'b1);
    step();
    chk("b2_edge_locked", locked, 1'b1);
    step();
    chk("b2_drop_locked", locked, 1'b0);
    chk("b2_hold_h_total", h_total, 20);
    chk("b2_hold_h_active", h_active, 12);
    chk("b2_hold_v_total", v_total, 12);
    chk("b2_hold_v_active", v_active, 8);
    chk("b2_no_pulse", mode_changed, 1'b0);
    run_to_frame_start();
    run_frames(1);
    check_lock("lock_b", 30, 20, 15, 10, 1'b1);
    run_to_frame_start();

    // vsync stops: timeout counted from the last vsync edge
    vs_en = 1'b0;
    for (int k = 0; k < 20000 && signal_lost !== 1'b1; k++) step();
    chk("to_clock", steps, last_edge_step + TO + 1);
    chk("to_signal_lost", signal_lost, 1'b1);
    chk("to_locked", locked, 1'b0);
    chk("to_hold_h_total", h_total, 30);
    run_to_frame_start();
    vs_en = 1'b1;
    step();
    step();
    chk("to_clear_signal_lost", signal_lost, 1'b0);
    run_to_frame_start();
    run_frames(2);
    check_lock("relock_b", 30, 20, 15, 10, 1'b0);

    // asynchronous reset mid-frame
    repeat (100) step();
    reset_n = 1'b0;
    #1;
    chk("mid_rst_h_total", h_total, 0);
    chk("mid_rst_v_active", v_active, 0);
    chk("mid_rst_locked", locked, 1'b0);
    chk("mid_rst_signal_lost", signal_lost, 1'b0);
    repeat (3) step();
    reset_n = 1'b1;
    run_to_frame_start();
    run_frames(3);
    check_lock("post_rst", 30, 20, 15, 10, 1'b1);
    run_to_frame_start();

    // 5000-clock lines: horizontal counter saturates, frames are invalid
    set_geom(5000, 12, 1, 1);
    run_frames(1);
    chk("sat_c1_locked", locked, 1'b1);
    step();
    step();
    chk("sat_drop_locked", locked, 1'b0);
    run_to_frame_start();
    run_frames(1);
    step();
    step();
    step();
    chk("sat_stays_unlocked", locked, 1'b0);
    chk("sat_hold_h_total", h_total, 30);
    step();
    chk("sat_no_pulse", mode_changed, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
